// File: rtl/fifo_rd_arb_pkg.sv
// Shared types, defaults and index helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_STALL_MAX  = 8;

  // Widest requester vector the helpers support.
  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_picker
  import fifo_rd_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner_idx,
  output logic [N_REQ-1:0] winner_onehot
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    any        = 1'b0;
    winner_idx = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any        = 1'b1;
        winner_idx = cand_idx;
      end
    end
    winner_onehot = any ? N_REQ'(idx_to_onehot(32'(winner_idx))) : '0;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO read port among N_REQ consumers (RCLK domain).
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int STALL_MAX  = DEF_STALL_MAX
) (
  input  logic                     RCLK,
  input  logic                     RRSTn,
  input  logic [N_REQ-1:0]         req,
  input  logic                     fifo_empty,
  input  logic [DATA_WIDTH-1:0]    fifo_rdata,
  output logic                     fifo_read,
  output logic [N_REQ-1:0]         grant,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic [$clog2(N_REQ)-1:0] rd_dest,
  output logic                     burst_done
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               burst_done_q, burst_done_d;
  logic               release_grant;

  logic               rd_valid_q;
  logic [IDX_W-1:0]   rd_dest_q;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req           (req),
    .rr_ptr        (rr_ptr_q),
    .any           (pick_any),
    .winner_idx    (pick_idx),
    .winner_onehot (pick_onehot)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_d        = beat_q;
    stall_d       = stall_q;
    burst_done_d  = 1'b0;
    fifo_read     = 1'b0;
    release_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          beat_d  = '0;
          stall_d = '0;
        end
      end

      BURST: begin
        fifo_read = req[owner_q] & ~fifo_empty;

        if (fifo_read) begin
          beat_d  = beat_q + BEAT_W'(1);
          stall_d = '0;
        end else if (req[owner_q]) begin
          stall_d = stall_q + STALL_W'(1);
        end

        // Burst complete, consumer gone, or FIFO starved for too long.
        release_grant = !req[owner_q]
                      || (fifo_read && beat_q == BEAT_W'(BURST_LEN - 1))
                      || (fifo_empty && stall_q == STALL_W'(STALL_MAX - 1));

        if (release_grant) begin
          state_d      = IDLE;
          grant_d      = '0;
          beat_d       = '0;
          stall_d      = '0;
          burst_done_d = 1'b1;
          rr_ptr_d     = IDX_W'(next_idx(32'(owner_q), N_REQ));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_q       <= '0;
      stall_q      <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_q       <= beat_d;
      stall_q      <= stall_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Return path: the FIFO presents data the cycle after the strobe, tagged with the owner at read time.
  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      rd_valid_q <= 1'b0;
      rd_dest_q  <= '0;
    end else begin
      rd_valid_q <= fifo_read;
      if (fifo_read) rd_dest_q <= owner_q;
    end
  end

  assign grant      = grant_q;
  assign burst_done = burst_done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_dest    = rd_dest_q;
  assign rd_data    = rd_valid_q ? fifo_rdata : '0;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter with a behavioural FIFO read side.
module tb_fifo_rd_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int BL    = 4;
  localparam int SM    = 8;

  logic          RCLK = 1'b0;
  logic          RRSTn;
  logic [3:0]    req;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_read;
  logic [3:0]    grant;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    rd_dest;
  logic          burst_done;

  fifo_rd_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .STALL_MAX  (SM)
  ) dut (
    .RCLK       (RCLK),
    .RRSTn      (RRSTn),
    .req        (req),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_read  (fifo_read),
    .grant      (grant),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_dest    (rd_dest),
    .burst_done (burst_done)
  );

  always #5 RCLK = ~RCLK;

  // Behavioural FIFO: written by the stimulus on falling edges, popped on rising edges.
  logic [7:0] mem [64];
  logic [5:0] wr_idx = '0;
  logic [5:0] rd_idx = '0;
  assign fifo_empty = (wr_idx == rd_idx);

  int reads_in_grant = 0;
  int illegal_reads  = 0;
  int over_reads     = 0;

  always @(posedge RCLK) begin
    if (fifo_read) begin
      fifo_rdata <= mem[rd_idx];
      rd_idx     <= rd_idx + 6'd1;
      if (fifo_empty) illegal_reads <= illegal_reads + 1;
      if (reads_in_grant >= BL) over_reads <= over_reads + 1;
    end
    if (grant == 4'b0)  reads_in_grant <= 0;
    else if (fifo_read) reads_in_grant <= reads_in_grant + 1;
  end

  // Output monitor: returned words, new grants, release pulses, back-to-back grants.
  logic [9:0] ret_q [$];
  logic [3:0] gnt_q [$];
  logic [3:0] prev_grant = '0;
  int         bd_n = 0;
  int         b2b_n = 0;

  always @(negedge RCLK) begin
    if (rd_valid) ret_q.push_back({rd_dest, rd_data});
    if (grant != 4'b0 && prev_grant == 4'b0) gnt_q.push_back(grant);
    if (grant != 4'b0 && prev_grant != 4'b0 && grant != prev_grant) b2b_n <= b2b_n + 1;
    if (burst_done) bd_n <= bd_n + 1;
    prev_grant <= grant;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge RCLK);
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx] = first + 8'(i);
      wr_idx      = wr_idx + 6'd1;
    end
  endtask

  task automatic clear_logs();
    ret_q.delete();
    gnt_q.delete();
  endtask

  logic [9:0] exp_q [$];
  int         bd_base;

  task automatic check_returns(input string tag);
    check({tag, "_count"}, 32'(ret_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < ret_q.size()) check(tag, 32'(ret_q[i]), 32'(exp_q[i]));
      else                  check(tag, 32'h3ff_ffff, 32'(exp_q[i]));
    end
  endtask

  initial begin
    // Reset with every consumer requesting.
    RRSTn = 1'b0;
    req   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_fifo_read", 32'(fifo_read), 32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
    end
    RRSTn = 1'b1;
    step(1);
    check("rst_release_grant", 32'(grant), 32'h1);
    check("rst_release_no_read_empty", 32'(fifo_read), 32'h0);
    req = 4'h0;
    step(1);
    check("drop_release_grant", 32'(grant), 32'h0);
    check("drop_release_done", 32'(burst_done), 32'h1);
    step(1);
    check("done_is_pulse", 32'(burst_done), 32'h0);

    // Single consumer, six words: full burst of four, one bubble, then the remaining two.
    clear_logs();
    bd_base = bd_n;
    push_words(8'h10, 6);
    req = 4'b0010;
    step(1);
    check("burst_grant", 32'(grant), 32'h2);
    check("burst_read", 32'(fifo_read), 32'h1);
    step(4);
    check("burst_release_grant", 32'(grant), 32'h0);
    check("burst_release_done", 32'(burst_done), 32'h1);
    check("burst_last_valid", 32'(rd_valid), 32'h1);
    check("burst_last_data", 32'(rd_data), 32'h13);
    check("burst_last_dest", 32'(rd_dest), 32'h1);
    step(1);
    check("bubble_regrant", 32'(grant), 32'h2);
    check("bubble_done_low", 32'(burst_done), 32'h0);
    step(2);
    req = 4'b0000;
    step(3);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({2'd1, 8'h10 + 8'(i)});
    check_returns("burst_ret");
    check("burst_grant_count", 32'(gnt_q.size()), 32'd2);
    check("burst_done_count", 32'(bd_n - bd_base), 32'd2);

    // Round-robin across all four from a fresh rr_ptr.
    RRSTn = 1'b0;
    step(1);
    RRSTn = 1'b1;
    clear_logs();
    push_words(8'h30, 20);
    req = 4'hF;
    step(25);
    req = 4'h0;
    step(3);
    check("rr_grant_count", 32'(gnt_q.size()), 32'd5);
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      if (g < gnt_q.size()) check("rr_grant_order", 32'(gnt_q[g]), 32'(oh));
    end
    exp_q.delete();
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({2'(g % 4), 8'h30 + 8'(g * 4 + k)});
    check_returns("rr_ret");

    // Empty stall: consumer 2 gets one word, then starves until timeout; 3 is next.
    clear_logs();
    push_words(8'h55, 1);
    req = 4'b1100;
    step(1);
    check("stall_grant", 32'(grant), 32'h4);
    step(1);
    check("stall_word_valid", 32'(rd_valid), 32'h1);
    check("stall_word_data", 32'(rd_data), 32'h55);
    check("stall_word_dest", 32'(rd_dest), 32'h2);
    check("stall_no_read", 32'(fifo_read), 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("stall_hold_grant", 32'(grant), 32'h4);
      check("stall_hold_no_read", 32'(fifo_read), 32'h0);
    end
    step(1);
    check("stall_release_grant", 32'(grant), 32'h0);
    check("stall_release_done", 32'(burst_done), 32'h1);
    step(1);
    check("stall_next_grant", 32'(grant), 32'h8);
    req = 4'h0;
    step(2);

    // Request drop after two reads; the second word returns to consumer 0.
    clear_logs();
    push_words(8'h60, 4);
    req = 4'b0001;
    step(1);
    check("drop_grant", 32'(grant), 32'h1);
    step(1);
    check("drop_w1_data", 32'(rd_data), 32'h60);
    step(1);
    check("drop_w2_valid", 32'(rd_valid), 32'h1);
    check("drop_w2_data", 32'(rd_data), 32'h61);
    check("drop_w2_dest", 32'(rd_dest), 32'h0);
    req = 4'b0000;
    #1;
    check("drop_no_read", 32'(fifo_read), 32'h0);
    step(1);
    check("drop_rel_grant", 32'(grant), 32'h0);
    check("drop_rel_done", 32'(burst_done), 32'h1);
    check("drop_rel_no_valid", 32'(rd_valid), 32'h0);
    wr_idx = rd_idx;

    // Reset right after a read: the in-flight word is dropped and rr_ptr returns to 0.
    clear_logs();
    push_words(8'h70, 4);
    req = 4'b0010;
    step(1);
    check("midrst_grant", 32'(grant), 32'h2);
    check("midrst_read", 32'(fifo_read), 32'h1);
    @(posedge RCLK);
    #1;
    RRSTn = 1'b0;
    #1;
    check("midrst_grant_zero", 32'(grant), 32'h0);
    check("midrst_read_zero", 32'(fifo_read), 32'h0);
    check("midrst_valid_zero", 32'(rd_valid), 32'h0);
    check("midrst_data_zero", 32'(rd_data), 32'h0);
    check("midrst_dest_zero", 32'(rd_dest), 32'h0);
    check("midrst_done_zero", 32'(burst_done), 32'h0);
    step(1);
    wr_idx = rd_idx;
    req    = 4'hF;
    RRSTn  = 1'b1;
    step(1);
    check("midrst_rrptr_zero", 32'(grant), 32'h1);
    check("midrst_no_return", 32'(ret_q.size()), 32'd0);
    req = 4'h0;
    step(3);

    check("never_read_empty", 32'(illegal_reads), 32'd0);
    check("never_over_burst", 32'(over_reads), 32'd0);
    check("never_back_to_back", 32'(b2b_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
